// File: rtl/cushion_pkg.sv
// Shared types and constants for the out-of-order commit cushion.
// Lane results travel through the lane FIFOs as lane_res_t.
package cushion_pkg;

  localparam int EXC_W          = 4;
  localparam int AUX_JMP_BIT    = 0;
  localparam int AUX_CHMODE_BIT = 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic             reg_w_en;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic             exc_en;
    logic [EXC_W-1:0] exc_code;
  } lane_res_t;

  // Width of a lane index; never below 1 bit so a single lane still has a port.
  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cushion_fifo.sv
// Synchronous FIFO with flush and async active-low reset.
// Readies are pure "not full": a push into a full FIFO is dropped even if a pop happens.
module cushion_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cushion_ooo.sv
// Merges main and coprocessor lane results into one in-order commit stream,
// using a dispatch-order queue of lane indices to pick the next lane to drain.
module cushion_ooo
  import cushion_pkg::*;
#(
  parameter int COP_NUMS    = 1,
  parameter int LANE_DEPTH  = 2,
  parameter int ORDER_DEPTH = 8,
  parameter int AUX_W       = 128
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic                                    mmu_wait,
  input  logic                                    dispatch_en,
  input  logic [lane_w(COP_NUMS+1)-1:0]           dispatch_lane,
  output logic                                    dispatch_ready,
  input  logic [COP_NUMS:0]                       lane_valid,
  output logic [COP_NUMS:0]                       lane_ready,
  input  logic [COP_NUMS:0][31:0]                 lane_pc,
  input  logic [COP_NUMS:0]                       lane_reg_w_en,
  input  logic [COP_NUMS:0][4:0]                  lane_reg_w_rd,
  input  logic [COP_NUMS:0][31:0]                 lane_reg_w_data,
  input  logic [COP_NUMS:0]                       lane_exc_en,
  input  logic [COP_NUMS:0][EXC_W-1:0]            lane_exc_code,
  input  logic [AUX_W-1:0]                        main_aux,
  output logic                                    cushion_valid,
  output logic [31:0]                             cushion_pc,
  output logic                                    cushion_reg_w_en,
  output logic [4:0]                              cushion_reg_w_rd,
  output logic [31:0]                             cushion_reg_w_data,
  output logic [AUX_W-1:0]                        cushion_aux,
  output logic                                    cushion_exc_en,
  output logic [EXC_W-1:0]                        cushion_exc_code,
  output logic [31:0]                             cushion_exc_pc,
  output logic                                    err
);

  localparam int L     = COP_NUMS + 1;
  localparam int LW    = lane_w(L);
  localparam int RES_W = $bits(lane_res_t);

  logic                 ord_full, ord_empty;
  logic [LW-1:0]        ord_head;
  logic [L-1:0]         lane_full, lane_empty, lane_pop;
  lane_res_t [L-1:0]    lane_head;
  logic [AUX_W-1:0]     aux_head;
  state_t               state;
  lane_res_t            cur;
  logic                 head_ok, head_main, commit, trap;

  assign dispatch_ready = !ord_full;
  assign lane_ready     = ~lane_full;

  cushion_fifo #(.W(LW), .DEPTH(ORDER_DEPTH)) u_order (
    .clk, .rst_n, .flush,
    .push(dispatch_en), .din(dispatch_lane), .pop(commit),
    .dout(ord_head), .full(ord_full), .empty(ord_empty)
  );

  for (genvar k = 0; k < L; k++) begin : g_lane
    lane_res_t din;
    assign din = '{pc: lane_pc[k], reg_w_en: lane_reg_w_en[k], rd: lane_reg_w_rd[k],
                   data: lane_reg_w_data[k], exc_en: lane_exc_en[k],
                   exc_code: lane_exc_code[k]};
    if (k == 0) begin : g_main
      // The main lane carries the side-effect bundle alongside its result.
      logic [RES_W+AUX_W-1:0] dout;
      cushion_fifo #(.W(RES_W + AUX_W), .DEPTH(LANE_DEPTH)) u_fifo (
        .clk, .rst_n, .flush,
        .push(lane_valid[k]), .din({din, main_aux}), .pop(lane_pop[k]),
        .dout(dout), .full(lane_full[k]), .empty(lane_empty[k])
      );
      assign lane_head[k] = dout[AUX_W +: RES_W];
      assign aux_head     = dout[AUX_W-1:0];
    end else begin : g_cop
      cushion_fifo #(.W(RES_W), .DEPTH(LANE_DEPTH)) u_fifo (
        .clk, .rst_n, .flush,
        .push(lane_valid[k]), .din(din), .pop(lane_pop[k]),
        .dout(lane_head[k]), .full(lane_full[k]), .empty(lane_empty[k])
      );
    end
  end

  always_comb begin
    head_ok   = 1'b0;
    cur       = '0;
    lane_pop  = '0;
    head_main = (ord_head == '0);
    for (int k = 0; k < L; k++) begin
      if (ord_head == LW'(k)) begin
        head_ok = !lane_empty[k];
        cur     = lane_head[k];
      end
    end
    commit = (state == ST_RUN) && !mmu_wait && !flush && !ord_empty && head_ok;
    for (int k = 0; k < L; k++) lane_pop[k] = commit && (ord_head == LW'(k));
    trap = cur.exc_en || (head_main && (aux_head[AUX_JMP_BIT] || aux_head[AUX_CHMODE_BIT]));
  end

  // Commit FSM with registered outputs; MMU stall freezes everything but err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_RUN;
      err                <= 1'b0;
      cushion_valid      <= 1'b0;
      cushion_pc         <= '0;
      cushion_reg_w_en   <= 1'b0;
      cushion_reg_w_rd   <= '0;
      cushion_reg_w_data <= '0;
      cushion_aux        <= '0;
      cushion_exc_en     <= 1'b0;
      cushion_exc_code   <= '0;
      cushion_exc_pc     <= '0;
    end else begin
      if ((dispatch_en && ord_full) || (|(lane_valid & lane_full))) err <= 1'b1;
      if (flush) begin
        state              <= ST_RUN;
        cushion_valid      <= 1'b0;
        cushion_pc         <= '0;
        cushion_reg_w_en   <= 1'b0;
        cushion_reg_w_rd   <= '0;
        cushion_reg_w_data <= '0;
        cushion_aux        <= '0;
        cushion_exc_en     <= 1'b0;
        cushion_exc_code   <= '0;
        cushion_exc_pc     <= '0;
      end else if (!mmu_wait) begin
        cushion_valid      <= commit;
        cushion_pc         <= commit ? cur.pc : '0;
        cushion_reg_w_en   <= commit && cur.reg_w_en;
        cushion_reg_w_rd   <= commit ? cur.rd : '0;
        cushion_reg_w_data <= commit ? cur.data : '0;
        cushion_aux        <= (commit && head_main) ? aux_head : '0;
        cushion_exc_en     <= commit && cur.exc_en;
        cushion_exc_code   <= commit ? cur.exc_code : '0;
        cushion_exc_pc     <= (commit && cur.exc_en) ? cur.pc : '0;
        if (commit && trap) state <= ST_HALT;
      end
    end
  end

endmodule

// File: doc/cushion_ooo.md
Name: cushion_ooo

Overview:
- Generalised successor of the pipeline cushion stage. Merges results from the main execution lane and COP_NUMS coprocessor lanes into one in-order commit stream feeding writeback/MMU.
- Each lane has its own result FIFO. A dispatch-order queue records which lane owns each issued instruction, so lanes may finish in any order.
- Adds flush, MMU stall hold, and halt-after-trap behaviour.

Parameters:
- COP_NUMS, 1, number of coprocessor lanes; total lanes L = COP_NUMS+1, lane 0 = main.
- LANE_DEPTH, 2, per-lane result FIFO depth; power of 2, at least 2.
- ORDER_DEPTH, 8, dispatch-order queue depth; power of 2, at least 2.
- AUX_W, 128, width of the main-only side-effect bundle (csr/mem/jmp/chmode fields, opaque here).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear of all queues and output.
- MMU_WAIT  in  1  holds output registers and blocks commit.
- DISPATCH_EN  in  1  an instruction is issued this cycle.
- DISPATCH_LANE  in  clog2(L)  owning lane of the issued instruction.
- DISPATCH_READY  out  1  order queue not full.
- LANE_VALID  in  L  result strobe per lane.
- LANE_READY  out  L  per-lane FIFO not full.
- LANE_PC  in  32*L  per-lane PC.
- LANE_REG_W_EN  in  L  per-lane register-write enable.
- LANE_REG_W_RD  in  5*L  per-lane destination register.
- LANE_REG_W_DATA  in  32*L  per-lane write data.
- LANE_EXC_EN  in  L  per-lane exception flag.
- LANE_EXC_CODE  in  4*L  per-lane exception code.
- MAIN_AUX  in  AUX_W  side effects for lane 0 only.
- CUSHION_VALID  out  1  committed entry this cycle.
- CUSHION_PC  out  32  committed PC.
- CUSHION_REG_W_EN  out  1  committed register-write enable.
- CUSHION_REG_W_RD  out  5  committed destination register.
- CUSHION_REG_W_DATA  out  32  committed write data.
- CUSHION_AUX  out  AUX_W  committed side-effect bundle.
- CUSHION_EXC_EN  out  1  committed exception flag.
- CUSHION_EXC_CODE  out  4  committed exception code.
- CUSHION_EXC_PC  out  32  PC of the committed exception.
- ERR  out  1  sticky protocol error.

Behaviour:
- Reset (RST_N=0, async): all FIFOs empty; all outputs 0; state RUN; ERR=0.
- FLUSH (sync, wins over everything except reset): FIFOs emptied, outputs 0, state to RUN. ERR is kept.
- Order queue push: DISPATCH_EN && DISPATCH_READY.
- Lane k FIFO push: LANE_VALID[k] && LANE_READY[k].
- Readies are pure "not full" with no pass-through. A push into a full queue is dropped and sets ERR.
- Commit condition: state RUN && !MMU_WAIT && order queue non-empty && head lane FIFO non-empty.
- On commit: pop both heads and register the payload to the outputs, so CUSHION_VALID=1 for one cycle.
- Lanes other than 0 drive CUSHION_AUX=0.
- CUSHION_EXC_PC = committed PC when EXC_EN is set, else 0.
- No commit and !MMU_WAIT: CUSHION_VALID and all payload outputs drop to 0.
- MMU_WAIT=1: output registers hold their values; queues still accept pushes.
- Latency: a result written to an empty lane FIFO whose lane is at the order head appears on the outputs 2 cycles after LANE_VALID (FIFO write, then output register).
- At most one commit per cycle.
- Simultaneous push and pop on any queue: permitted when not full; count unchanged; pointers wrap modulo depth.
- Order queue empty with a lane FIFO non-empty: the lane FIFO waits, no error.
- States:
  - RUN: normal operation.
  - HALT: entered on committing an entry with EXC_EN, or with the lane-0 jump/chmode bits (AUX bits [1:0], defined in the package) set.
  - In HALT no further commits occur; outputs go to 0 after the trap cycle; pushes are still accepted.
  - HALT exits only via FLUSH or reset.
- A FLUSH arriving in the same cycle as a commit cancels that commit.

Decomposition:
- cushion_pkg:
  - Lane index width function (clog2).
  - Exception code width 4.
  - AUX bit positions for jmp_do/chmode_do.
  - State encoding RUN=0, HALT=1.
- Sub-module cushion_fifo: parametrised width/depth sync FIFO with full/empty, flush, and async active-low reset. Instantiated L times for the lanes and once, with lane-index width, for the order queue.

Test Plan:
- Dispatch lanes 0,1 (PCs 0x100, 0x104); lane 1 result first, lane 0 two cycles later → commits 0x100 then 0x104 on consecutive cycles.
- Lane 0 result with EXC_EN=1, code 0x2, PC 0x200, then more queued results → single commit with EXC_PC=0x200; no further CUSHION_VALID until FLUSH.
- MMU_WAIT asserted 3 cycles while output shows PC 0x300 → outputs hold 0x300; next entry commits the cycle after MMU_WAIT drops.
- Fill lane 1 FIFO to LANE_DEPTH → LANE_READY[1]=0; an extra LANE_VALID[1] sets ERR=1 and the entry is not stored.
- FLUSH with 5 outstanding dispatches, then fresh dispatch PC 0x400 and result → only 0x400 commits; state RUN.
- Assert RST_N low mid-commit, asynchronously → outputs 0 immediately; DISPATCH_READY=1 after release.
